// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control sequencer: field widths, op codes,
// state encoding, strobe bundle and op classification helpers.
package alu_pkg;

    localparam int SEL_W = 4;
    localparam int OP_W  = 5;

    localparam logic [OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB = 5'd1;
    localparam logic [OP_W-1:0] OP_AND = 5'd2;
    localparam logic [OP_W-1:0] OP_OR  = 5'd3;
    localparam logic [OP_W-1:0] OP_SHR = 5'd4;
    localparam logic [OP_W-1:0] OP_SHL = 5'd5;
    localparam logic [OP_W-1:0] OP_ROR = 5'd6;
    localparam logic [OP_W-1:0] OP_ROL = 5'd7;
    localparam logic [OP_W-1:0] OP_NEG = 5'd8;
    localparam logic [OP_W-1:0] OP_NOT = 5'd9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_T_RA   = 3'd1,
        ST_T_RB   = 3'd2,
        ST_T_WB   = 3'd3,
        ST_T_DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             bus_src_en;
        logic [SEL_W-1:0] bus_src_sel;
        logic             y_in;
        logic             z_in;
        logic             z_out;
        logic             reg_wr_en;
        logic [SEL_W-1:0] reg_wr_sel;
        logic [OP_W-1:0]  alu_op;
    } strobe_t;

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_NOT);
    endfunction

    // Unary ops take their single operand from the B slot and skip the Y load.
    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational T-state to datapath strobe table for the ALU sequencer.
module alu_seq_decode
    import alu_pkg::*;
(
    input  state_t           state,
    input  logic [OP_W-1:0]  op,
    input  logic [SEL_W-1:0] ra,
    input  logic [SEL_W-1:0] rb,
    input  logic [SEL_W-1:0] rd,
    output strobe_t          strb
);

    // Strobe table: everything idles at zero, each T-state raises its own set.
    always_comb begin
        strb = '0;
        case (state)
            ST_IDLE: begin
                strb = '0;
            end
            ST_T_RA: begin
                strb.busy        = 1'b1;
                strb.bus_src_en  = 1'b1;
                strb.bus_src_sel = ra;
                strb.y_in        = 1'b1;
            end
            ST_T_RB: begin
                strb.busy        = 1'b1;
                strb.bus_src_en  = 1'b1;
                strb.bus_src_sel = rb;
                strb.alu_op      = op;
                strb.z_in        = 1'b1;
            end
            ST_T_WB: begin
                strb.busy       = 1'b1;
                strb.z_out      = 1'b1;
                strb.reg_wr_en  = 1'b1;
                strb.reg_wr_sel = rd;
            end
            ST_T_DONE: begin
                strb.busy = 1'b1;
                strb.done = 1'b1;
            end
            default: begin
                strb = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle control sequencer for the shared-bus ALU datapath. Outputs are
// registered from the decoded next state so they change only on clock edges.
module alu_seq
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [SEL_W-1:0] ra_sel,
    input  logic [SEL_W-1:0] rb_sel,
    input  logic [SEL_W-1:0] rd_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             bus_src_en,
    output logic [SEL_W-1:0] bus_src_sel,
    output logic             y_in,
    output logic             z_in,
    output logic             z_out,
    output logic             reg_wr_en,
    output logic [SEL_W-1:0] reg_wr_sel,
    output logic [OP_W-1:0]  alu_op
);

    state_t           state_r;
    state_t           state_next_s;
    logic [OP_W-1:0]  op_r;
    logic [OP_W-1:0]  op_next_s;
    logic [SEL_W-1:0] ra_r;
    logic [SEL_W-1:0] ra_next_s;
    logic [SEL_W-1:0] rb_r;
    logic [SEL_W-1:0] rb_next_s;
    logic [SEL_W-1:0] rd_r;
    logic [SEL_W-1:0] rd_next_s;
    logic             err_r;
    logic             err_next_s;
    strobe_t          strb_r;
    strobe_t          strb_next_s;

    // Next-state and field-latch logic; requests are only looked at in IDLE.
    always_comb begin
        state_next_s = state_r;
        op_next_s    = op_r;
        ra_next_s    = ra_r;
        rb_next_s    = rb_r;
        rd_next_s    = rd_r;
        err_next_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (is_legal(op)) begin
                        op_next_s    = op;
                        ra_next_s    = ra_sel;
                        rb_next_s    = rb_sel;
                        rd_next_s    = rd_sel;
                        state_next_s = is_unary(op) ? ST_T_RB : ST_T_RA;
                    end else begin
                        err_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_T_RA:   state_next_s = ST_T_RB;
            ST_T_RB:   state_next_s = ST_T_WB;
            ST_T_WB:   state_next_s = ST_T_DONE;
            ST_T_DONE: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    alu_seq_decode u_decode (
        .state (state_next_s),
        .op    (op_next_s),
        .ra    (ra_next_s),
        .rb    (rb_next_s),
        .rd    (rd_next_s),
        .strb  (strb_next_s)
    );

    // State, latched fields and output registers; clr aborts any operation.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r <= ST_IDLE;
            op_r    <= '0;
            ra_r    <= '0;
            rb_r    <= '0;
            rd_r    <= '0;
            err_r   <= 1'b0;
            strb_r  <= '0;
        end else begin
            state_r <= state_next_s;
            op_r    <= op_next_s;
            ra_r    <= ra_next_s;
            rb_r    <= rb_next_s;
            rd_r    <= rd_next_s;
            err_r   <= err_next_s;
            strb_r  <= strb_next_s;
        end
    end

    assign busy        = strb_r.busy;
    assign done        = strb_r.done;
    assign err         = err_r;
    assign bus_src_en  = strb_r.bus_src_en;
    assign bus_src_sel = strb_r.bus_src_sel;
    assign y_in        = strb_r.y_in;
    assign z_in        = strb_r.z_in;
    assign z_out       = strb_r.z_out;
    assign reg_wr_en   = strb_r.reg_wr_en;
    assign reg_wr_sel  = strb_r.reg_wr_sel;
    assign alu_op      = strb_r.alu_op;

endmodule
